// File: rtl/bcd_code5_tx.sv
// bcd_code5_tx: BCD digit to 2-of-5 (weights 7,4,2,1,0) encoder with parallel output and UART-like serial frame.
// Optional 2-entry input digit FIFO is enabled by defining CODE5_TX_FIFO_EN.
module bcd_code5_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [4:0] code_o,
    output logic       code_valid_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [4:0]  code_q, code_d;
    logic        code_valid_q, code_valid_d;
    logic        err_q, err_d;
    logic        load;
    logic [3:0]  load_digit;
    logic        bit_done;

    function automatic logic [4:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    return 5'b11000;
            4'd1:    return 5'b00011;
            4'd2:    return 5'b00101;
            4'd3:    return 5'b00110;
            4'd4:    return 5'b01001;
            4'd5:    return 5'b01010;
            4'd6:    return 5'b01100;
            4'd7:    return 5'b10001;
            4'd8:    return 5'b10010;
            4'd9:    return 5'b10100;
            default: return 5'b00000;
        endcase
    endfunction

`ifdef CODE5_TX_FIFO_EN
    logic [3:0] fifo_q [2];
    logic [3:0] fifo_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push;
    logic       pop;

    assign ready_o    = (count_q != 2'd2);
    assign push       = valid_i && ready_o;
    // The encoder only consumes a digit when the serialiser is free.
    assign pop        = (state_q == IDLE) && (count_q != 2'd0);
    assign load       = pop;
    assign load_digit = fifo_q[rd_ptr_q];

    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = digit_i;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            fifo_q    <= fifo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end
`else
    assign ready_o    = (state_q == IDLE);
    assign load       = valid_i && ready_o;
    assign load_digit = digit_i;
`endif

    assign bit_done = (cnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
        end
    end

    // idx_q counts data bits in DATA and stop bits in STOP, so cnt_q never spans more than one bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (load) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd4) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        code_d       = code_q;
        code_valid_d = 1'b0;
        err_d        = 1'b0;
        if (load) begin
            code_d       = encode(load_digit);
            code_valid_d = 1'b1;
            err_d        = (load_digit > 4'd9);
        end
    end

    always_comb begin
        tx_o   = 1'b1;
        busy_o = 1'b1;
        case (state_q)
            IDLE:    busy_o = 1'b0;
            START:   tx_o   = 1'b0;
            DATA:    tx_o   = code_q[3'd4 - idx_q];
            STOP:    tx_o   = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

    assign code_o       = code_q;
    assign code_valid_o = code_valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_bcd_code5_tx.sv
// tb_bcd_code5_tx: directed vectors for bcd_code5_tx checked against a frame-position model every cycle.
// Exercises the FIFO scenario instead of the direct-handshake scenarios when CODE5_TX_FIFO_EN is defined.
`timescale 1ns/1ps
module tb_bcd_code5_tx;

    localparam int CPB = 4;
    localparam int SB  = 1;
    localparam int FL  = (6 + SB) * CPB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] digit_i = 4'd0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [4:0] code_o;
    logic       code_valid_o;
    logic       tx_o;
    logic       busy_o;
    logic       err_o;

    bcd_code5_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_i      (digit_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int assert_count = 0;
    int fail_count   = 0;

    logic [4:0] code_table [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                    5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [4:0] model_code(input logic [3:0] d);
        return (d <= 4'd9) ? code_table[d] : 5'b00000;
    endfunction

    // Serial line value at a given cycle offset inside a frame (-1 means no frame).
    function automatic logic model_tx(input int pos, input logic [4:0] word);
        if (pos < 0)       return 1'b1;
        if (pos < CPB)     return 1'b0;
        if (pos < 6 * CPB) return word[4 - (pos / CPB - 1)];
        return 1'b1;
    endfunction

    int         m_pos  = -1;
    logic [4:0] m_word = 5'b0;
    logic       m_cv   = 1'b0;
    logic       m_err  = 1'b0;
    logic [3:0] m_fifo [2] = '{4'd0, 4'd0};
    int         m_cnt  = 0;
    logic       m_start;
    logic [3:0] m_digit;
    logic       m_push;
    logic       m_ready;

`ifdef CODE5_TX_FIFO_EN
    assign m_start = (m_pos < 0) && (m_cnt > 0);
    assign m_digit = m_fifo[0];
    assign m_ready = (m_cnt < 2);
    assign m_push  = valid_i && m_ready;
`else
    assign m_start = valid_i && (m_pos < 0);
    assign m_digit = digit_i;
    assign m_ready = (m_pos < 0);
    assign m_push  = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  <= -1;
            m_word <= 5'b0;
            m_cv   <= 1'b0;
            m_err  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (m_start) begin
                m_pos  <= 0;
                m_word <= model_code(m_digit);
                m_cv   <= 1'b1;
                m_err  <= (m_digit > 4'd9);
            end else begin
                m_cv  <= 1'b0;
                m_err <= 1'b0;
                if (m_pos >= 0) m_pos <= (m_pos == FL - 1) ? -1 : m_pos + 1;
            end
            case ({m_start && (m_cnt > 0), m_push})
                2'b10: begin
                    m_fifo[0] <= m_fifo[1];
                    m_cnt     <= m_cnt - 1;
                end
                2'b01: begin
                    m_fifo[m_cnt] <= digit_i;
                    m_cnt         <= m_cnt + 1;
                end
                2'b11: begin
                    if (m_cnt == 1) begin
                        m_fifo[0] <= digit_i;
                    end else begin
                        m_fifo[0] <= m_fifo[1];
                        m_fifo[1] <= digit_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        checkOutput("cmp_code_o", code_o, m_word);
        checkOutput("cmp_code_valid_o", code_valid_o, m_cv);
        checkOutput("cmp_err_o", err_o, m_err);
        checkOutput("cmp_tx_o", tx_o, model_tx(m_pos, m_word));
        checkOutput("cmp_busy_o", busy_o, m_pos >= 0);
        checkOutput("cmp_ready_o", ready_o, m_ready);
    end

    task automatic applyStimulus(input logic [3:0] d, input bit hold);
        bit done;
        done    = 1'b0;
        digit_i = d;
        valid_i = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (ready_o) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!hold) valid_i = 1'b0;
        if (!done) checkOutput("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic captureFrame(output logic [27:0] bits, output int rdy_hi, output int busy_n, output int cv_n);
        bits   = '0;
        rdy_hi = 0;
        busy_n = 0;
        cv_n   = 0;
        for (int i = 0; i < FL; i++) begin
            bits = {bits[26:0], tx_o};
            if (ready_o)      rdy_hi++;
            if (busy_o)       busy_n++;
            if (code_valid_o) cv_n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [27:0] frame;
        int          rdy_hi, busy_n, cv_n;
`ifdef CODE5_TX_FIFO_EN
        logic        tx_log   [100];
        logic        busy_log [100];
        int          starts   [3];
        int          n_starts;
        logic [4:0]  word;
        logic [4:0]  exp_words [3];
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_code_o", code_o, 5'b00000);
        checkOutput("reset_code_valid_o", code_valid_o, 1'b0);
        checkOutput("reset_tx_o", tx_o, 1'b1);
        checkOutput("reset_busy_o", busy_o, 1'b0);
        checkOutput("reset_err_o", err_o, 1'b0);
        checkOutput("reset_ready_o", ready_o, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef CODE5_TX_FIFO_EN
        exp_words = '{5'b00011, 5'b00101, 5'b01001};
        valid_i = 1'b1;
        digit_i = 4'd1;
        @(posedge clk);
        #1;
        checkOutput("fifo_ready_one_entry", ready_o, 1'b1);
        digit_i = 4'd2;
        @(posedge clk);
        #1;
        checkOutput("fifo_first_code", code_o, 5'b00011);
        digit_i = 4'd4;
        for (int i = 0; i < 100; i++) begin
            tx_log[i]   = tx_o;
            busy_log[i] = busy_o;
            if (i == 1) begin
                checkOutput("fifo_full_ready", ready_o, 1'b0);
                valid_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        n_starts = 0;
        starts   = '{999, 999, 999};
        for (int i = 0; i < 100; i++) begin
            if (busy_log[i] && (i == 0 || !busy_log[i - 1]) && n_starts < 3) begin
                starts[n_starts] = i;
                n_starts++;
            end
        end
        checkOutput("fifo_frame_count", n_starts, 3);
        checkOutput("fifo_first_start", starts[0], 0);
        checkOutput("fifo_gap_1_2", starts[1] - starts[0], 29);
        checkOutput("fifo_gap_2_3", starts[2] - starts[1], 29);
        for (int f = 0; f < 3; f++) begin
            word = 5'b0;
            if (starts[f] + 6 * CPB < 100) begin
                for (int k = 0; k < 5; k++) word[4 - k] = tx_log[starts[f] + CPB * (k + 1) + 2];
            end
            checkOutput("fifo_frame_word", word, exp_words[f]);
        end
`else
        applyStimulus(4'd5, 1'b0);
        checkOutput("d5_code_o", code_o, 5'b01010);
        checkOutput("d5_code_valid_o", code_valid_o, 1'b1);
        captureFrame(frame, rdy_hi, busy_n, cv_n);
        checkOutput("d5_frame", frame, 28'b0000_0000_1111_0000_1111_0000_1111);
        checkOutput("d5_busy_cycles", busy_n, 28);
        checkOutput("d5_ready_during_frame", rdy_hi, 0);
        checkOutput("d5_code_valid_pulses", cv_n, 1);
        checkOutput("d5_idle_busy_o", busy_o, 1'b0);
        checkOutput("d5_code_hold", code_o, 5'b01010);

        for (int d = 0; d < 10; d++) begin
            applyStimulus(4'(d), 1'b0);
            checkOutput("sweep_code_o", code_o, code_table[d]);
            checkOutput("sweep_two_ones", $countones(code_o), 2);
            checkOutput("sweep_err_o", err_o, 1'b0);
            captureFrame(frame, rdy_hi, busy_n, cv_n);
            checkOutput("sweep_busy_cycles", busy_n, 28);
        end

        applyStimulus(4'd12, 1'b0);
        checkOutput("d12_code_o", code_o, 5'b00000);
        checkOutput("d12_err_o", err_o, 1'b1);
        checkOutput("d12_code_valid_o", code_valid_o, 1'b1);
        captureFrame(frame, rdy_hi, busy_n, cv_n);
        checkOutput("d12_frame", frame, 28'h000000F);

        applyStimulus(4'd3, 1'b1);
        digit_i = 4'd7;
        checkOutput("b2b_first_code", code_o, 5'b00110);
        captureFrame(frame, rdy_hi, busy_n, cv_n);
        checkOutput("b2b_first_frame", frame, 28'b0000_0000_0000_1111_1111_0000_1111);
        checkOutput("b2b_first_ready_low", rdy_hi, 0);
        checkOutput("b2b_idle_ready", ready_o, 1'b1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        checkOutput("b2b_second_code", code_o, 5'b10001);
        checkOutput("b2b_second_code_valid", code_valid_o, 1'b1);
        captureFrame(frame, rdy_hi, busy_n, cv_n);
        checkOutput("b2b_second_frame", frame, 28'b0000_1111_0000_0000_0000_1111_1111);
        checkOutput("b2b_second_ready_low", rdy_hi, 0);

        applyStimulus(4'd8, 1'b0);
        repeat (13) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_pre_tx_o", tx_o, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_tx_o", tx_o, 1'b1);
        checkOutput("rst_mid_busy_o", busy_o, 1'b0);
        checkOutput("rst_mid_ready_o", ready_o, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        applyStimulus(4'd0, 1'b0);
        checkOutput("rst_after_code_o", code_o, 5'b11000);
        captureFrame(frame, rdy_hi, busy_n, cv_n);
        checkOutput("rst_after_frame", frame, 28'b0000_1111_1111_0000_0000_0000_1111);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
